// File: rtl/vga_rect_painter_pkg.sv
// Shared constants and types for the VGA rectangle painter: timing totals,
// config register map, reset geometry and the rectangle config payload.
package vga_rect_painter_pkg;

   localparam int unsigned H_ACTIVE   = 640;
   localparam int unsigned V_ACTIVE   = 480;
   localparam int unsigned H_TOTAL    = 800;
   localparam int unsigned V_TOTAL    = 525;
   localparam int unsigned HCNT_W     = 11;
   localparam int unsigned VCNT_W     = 10;
   localparam int unsigned CFG_ADDR_W = 3;
   localparam int unsigned CFG_DATA_W = 11;
   localparam int unsigned RGB_W      = 8;

   typedef enum logic [CFG_ADDR_W-1:0] {
      CFG_X0     = 3'd0,
      CFG_X1     = 3'd1,
      CFG_Y0     = 3'd2,
      CFG_Y1     = 3'd3,
      CFG_FG     = 3'd4,
      CFG_BG     = 3'd5,
      CFG_COMMIT = 3'd6,
      CFG_RSVD   = 3'd7
   } cfg_addr_e;

   typedef struct packed {
      logic [HCNT_W-1:0] x0;
      logic [HCNT_W-1:0] x1;
      logic [VCNT_W-1:0] y0;
      logic [VCNT_W-1:0] y1;
      logic [RGB_W-1:0]  fg;
      logic [RGB_W-1:0]  bg;
   } rect_cfg_t;

   localparam rect_cfg_t RECT_RST = '{
      x0: 11'd100,
      x1: 11'd300,
      y0: 10'd100,
      y1: 10'd200,
      fg: 8'hE0,
      bg: 8'hFF
   };

   localparam logic [RGB_W-1:0] RGB_BLANK = 8'h00;

endpackage

// File: rtl/vga_cfg_if.sv
// Valid/ready config write port for the rectangle painter.
interface vga_cfg_if;
   import vga_rect_painter_pkg::*;

   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [CFG_ADDR_W-1:0] cfg_addr;
   logic [CFG_DATA_W-1:0] cfg_data;

   modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);

endinterface

// File: rtl/vga_cfg_regs.sv
// Shadow/active rectangle registers; shadow copies to active only at the
// first blanking line so a frame never shows a partial update.
module vga_cfg_regs
   import vga_rect_painter_pkg::*;
#(
   parameter int unsigned V_ACT = vga_rect_painter_pkg::V_ACTIVE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [HCNT_W-1:0] hcount,
   input  logic [VCNT_W-1:0] vcount,
   vga_cfg_if.slave          cfg,
   output rect_cfg_t         active,
   output logic              commit_pending
);

   rect_cfg_t shadow_q, shadow_d;
   rect_cfg_t active_q, active_d;
   logic      pending_q, pending_d;
   logic      boundary_c;
   logic      ready_c;
   logic      wr_c;

   always_comb begin
      shadow_d   = shadow_q;
      active_d   = active_q;
      pending_d  = pending_q;
      boundary_c = (hcount == '0) && (vcount == VCNT_W'(V_ACT));
      // Commit cycle blocks writes so a COMMIT can never land on the boundary.
      ready_c    = !(boundary_c && pending_q);
      wr_c       = cfg.cfg_valid && ready_c;

      if (wr_c) begin
         case (cfg_addr_e'(cfg.cfg_addr))
            CFG_X0:     shadow_d.x0 = cfg.cfg_data;
            CFG_X1:     shadow_d.x1 = cfg.cfg_data;
            CFG_Y0:     shadow_d.y0 = cfg.cfg_data[VCNT_W-1:0];
            CFG_Y1:     shadow_d.y1 = cfg.cfg_data[VCNT_W-1:0];
            CFG_FG:     shadow_d.fg = cfg.cfg_data[RGB_W-1:0];
            CFG_BG:     shadow_d.bg = cfg.cfg_data[RGB_W-1:0];
            CFG_COMMIT: pending_d   = 1'b1;
            default:    ;
         endcase
      end

      if (boundary_c && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_q  <= RECT_RST;
         active_q  <= RECT_RST;
         pending_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
      end
   end

   assign cfg.cfg_ready   = ready_c;
   assign active          = active_q;
   assign commit_pending  = pending_q;

endmodule

// File: rtl/vga_rect_painter.sv
// Two-stage pixel colour pipeline: one filled rectangle over a background,
// with syncs delayed to stay aligned with the coloured pixels.
module vga_rect_painter
   import vga_rect_painter_pkg::*;
#(
   parameter int unsigned H_ACTIVE = vga_rect_painter_pkg::H_ACTIVE,
   parameter int unsigned V_ACTIVE = vga_rect_painter_pkg::V_ACTIVE,
   parameter int unsigned PIPE_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [HCNT_W-1:0] hcount,
   input  logic [VCNT_W-1:0] vcount,
   input  logic              hsync_in,
   input  logic              vsync_in,
   vga_cfg_if.slave          cfg,
   output logic              commit_pending,
   output logic [2:0]        red,
   output logic [2:0]        green,
   output logic [1:0]        blue,
   output logic              hsync,
   output logic              vsync
);

   rect_cfg_t act;

   vga_cfg_regs #(
      .V_ACT (V_ACTIVE)
   ) u_cfg_regs (
      .clk            (clk),
      .reset          (reset),
      .hcount         (hcount),
      .vcount         (vcount),
      .cfg            (cfg),
      .active         (act),
      .commit_pending (commit_pending)
   );

   logic                vis_q, vis_d;
   logic                in_q, in_d;
   logic [RGB_W-1:0]    rgb_q, rgb_d;
   logic [PIPE_LAT-1:0] hs_pipe_q, hs_pipe_d;
   logic [PIPE_LAT-1:0] vs_pipe_q, vs_pipe_d;

   always_comb begin
      vis_d = (hcount < HCNT_W'(H_ACTIVE)) && (vcount < VCNT_W'(V_ACTIVE));
      // Y compared zero-extended to the 11-bit coordinate width.
      in_d  = (hcount >= act.x0) && (hcount < act.x1) &&
              ({1'b0, vcount} >= {1'b0, act.y0}) &&
              ({1'b0, vcount} <  {1'b0, act.y1});
      if (!vis_q) begin
         rgb_d = RGB_BLANK;
      end else if (in_q) begin
         rgb_d = act.fg;
      end else begin
         rgb_d = act.bg;
      end
      hs_pipe_d = {hs_pipe_q[PIPE_LAT-2:0], hsync_in};
      vs_pipe_d = {vs_pipe_q[PIPE_LAT-2:0], vsync_in};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vis_q     <= 1'b0;
         in_q      <= 1'b0;
         rgb_q     <= RGB_BLANK;
         hs_pipe_q <= '1;
         vs_pipe_q <= '1;
      end else begin
         vis_q     <= vis_d;
         in_q      <= in_d;
         rgb_q     <= rgb_d;
         hs_pipe_q <= hs_pipe_d;
         vs_pipe_q <= vs_pipe_d;
      end
   end

   assign red   = rgb_q[7:5];
   assign green = rgb_q[4:2];
   assign blue  = rgb_q[1:0];
   assign hsync = hs_pipe_q[PIPE_LAT-1];
   assign vsync = vs_pipe_q[PIPE_LAT-1];

endmodule

// File: tb/tb_vga_rect_painter.sv
// Scoreboard bench for vga_rect_painter: coordinate stream and config writes
// are modelled from the register map; a monitor checks each pixel 2 cycles on.
module tb_vga_rect_painter;
   import vga_rect_painter_pkg::*;

   typedef struct {
      int rgb;
      int hs;
      int vs;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        hsync_in;
   logic        vsync_in;
   logic        commit_pending;
   logic [2:0]  red;
   logic [2:0]  green;
   logic [1:0]  blue;
   logic        hsync;
   logic        vsync;

   vga_cfg_if cfg_if ();

   vga_rect_painter dut (
      .clk            (clk),
      .reset          (reset),
      .hcount         (hcount),
      .vcount         (vcount),
      .hsync_in       (hsync_in),
      .vsync_in       (vsync_in),
      .cfg            (cfg_if),
      .commit_pending (commit_pending),
      .red            (red),
      .green          (green),
      .blue           (blue),
      .hsync          (hsync),
      .vsync          (vsync)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: index 0..5 = X0, X1, Y0, Y1, FG, BG
   int   sh[6];
   int   act[6];
   bit   m_pend;
   exp_t sb[$];
   int   n_checks;
   int   n_err;

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, want);
      end
   endtask

   task automatic load_def();
      sh  = '{100, 300, 100, 200, 'hE0, 'hFF};
      act = '{100, 300, 100, 200, 'hE0, 'hFF};
      m_pend = 1'b0;
   endtask

   // One clock of stimulus; the model advances as the DUT will at the next edge.
   task automatic issue(input int h, input int v, input bit rst,
                        input bit cv, input int ca, input int cd);
      exp_t e;
      bit   bnd, rdy, hs, vs, vis, inr, pend_before;
      @(negedge clk);
      hs  = !(h >= 656 && h < 752);
      vs  = !(v >= 490 && v < 492);
      reset    = rst;
      hcount   = 11'(h);
      vcount   = 10'(v);
      hsync_in = hs;
      vsync_in = vs;
      cfg_if.cfg_valid = cv;
      cfg_if.cfg_addr  = 3'(ca);
      cfg_if.cfg_data  = 11'(cd);
      bnd = (h == 0) && (v == V_ACTIVE);
      rdy = !(bnd && m_pend);
      #1;
      check("cfg_ready", int'(cfg_if.cfg_ready), int'(rdy));
      check("commit_pending", int'(commit_pending), int'(m_pend));

      if (rst) begin
         e = '{rgb: 0, hs: 1, vs: 1};
         if (sb.size() > 0) sb[sb.size()-1] = e;
         sb.push_back(e);
         load_def();
      end else begin
         vis = (h < H_ACTIVE) && (v < V_ACTIVE);
         inr = (h >= act[0]) && (h < act[1]) && (v >= act[2]) && (v < act[3]);
         e.rgb = !vis ? 0 : (inr ? act[4] : act[5]);
         e.hs  = int'(hs);
         e.vs  = int'(vs);
         sb.push_back(e);
         pend_before = m_pend;
         if (cv && rdy) begin
            case (ca)
               0, 1:    sh[ca] = cd & 'h7FF;
               2, 3:    sh[ca] = cd & 'h3FF;
               4, 5:    sh[ca] = cd & 'hFF;
               6:       m_pend = 1'b1;
               default: ;
            endcase
         end
         if (bnd && pend_before) begin
            act    = sh;
            m_pend = 1'b0;
         end
      end
   endtask

   function automatic int clampi(input int x, input int hi);
      if (x < 0) return 0;
      if (x > hi) return hi;
      return x;
   endfunction

   // Coordinates biased toward the rectangle edges a quarter of the time.
   task automatic pick(output int h, output int v);
      if ($urandom_range(0, 3) == 0) begin
         h = clampi(act[$urandom_range(0, 1)] + int'($urandom_range(0, 2)) - 1, H_TOTAL - 1);
         v = clampi(act[2 + $urandom_range(0, 1)] + int'($urandom_range(0, 2)) - 1, V_TOTAL - 1);
      end else begin
         h = int'($urandom_range(0, H_TOTAL - 1));
         v = int'($urandom_range(0, V_TOTAL - 1));
      end
   endtask

   task automatic idle(input int n);
      int h, v;
      for (int i = 0; i < n; i++) begin
         pick(h, v);
         issue(h, v, 1'b0, 1'b0, 0, 0);
      end
   endtask

   task automatic wr(input int a, input int d);
      int h, v;
      pick(h, v);
      if (h == 0 && v == V_ACTIVE) v = 0;
      issue(h, v, 1'b0, 1'b1, a, d);
   endtask

   task automatic boundary();
      issue(0, V_ACTIVE, 1'b0, 1'b0, 0, 0);
   endtask

   // Monitor: output after each edge reflects the issue two edges back.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() >= 2) begin
            e = sb.pop_front();
            check("rgb", int'({red, green, blue}), e.rgb);
            check("hsync", int'(hsync), e.hs);
            check("vsync", int'(vsync), e.vs);
         end
      end
   end

   initial begin
      int h, v;
      n_checks = 0;
      n_err    = 0;
      reset = 1'b1;
      hcount = '0;
      vcount = '0;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_addr  = '0;
      cfg_if.cfg_data  = '0;
      load_def();

      issue(0, 0, 1'b1, 1'b0, 0, 0);
      // Default rectangle spot pixels, including edges and blanking
      issue(100, 100, 1'b0, 1'b0, 0, 0);
      issue(300, 100, 1'b0, 1'b0, 0, 0);
      issue(99, 150, 1'b0, 1'b0, 0, 0);
      issue(640, 10, 1'b0, 1'b0, 0, 0);
      issue(299, 199, 1'b0, 1'b0, 0, 0);
      issue(100, 200, 1'b0, 1'b0, 0, 0);
      issue(700, 490, 1'b0, 1'b0, 0, 0);
      idle(300);

      // Shadow writes without COMMIT leave frames unchanged
      wr(0, 0); wr(1, 640); wr(2, 0); wr(3, 480); wr(4, 'h1C);
      idle(100); boundary(); idle(100);

      // COMMIT mid-frame; a write attempted on the boundary is refused
      issue(320, 240, 1'b0, 1'b1, 6, 0);
      idle(100);
      issue(0, V_ACTIVE, 1'b0, 1'b1, 4, 'h03);
      issue(0, 0, 1'b0, 1'b0, 0, 0);
      issue(639, 479, 1'b0, 1'b0, 0, 0);
      idle(200);

      // Zero-width rectangle shows only background
      wr(0, 300); wr(1, 300); wr(6, 0);
      idle(50); boundary(); idle(200);

      // Write in the cycle before the boundary joins the pending commit
      wr(0, 10); wr(1, 50); wr(2, 10); wr(3, 50); wr(4, 'h03); wr(6, 0);
      idle(20);
      issue(799, 479, 1'b0, 1'b1, 5, 'h92);
      boundary();
      issue(10, 10, 1'b0, 1'b0, 0, 0);
      issue(50, 49, 1'b0, 1'b0, 0, 0);
      idle(200);

      // Reset mid-line with a commit pending drops the commit
      wr(0, 0); wr(1, 640); wr(4, 'h55); wr(6, 0);
      idle(10);
      issue(320, 100, 1'b1, 1'b0, 0, 0);
      idle(20); boundary();
      issue(100, 100, 1'b0, 1'b0, 0, 0);
      issue(99, 150, 1'b0, 1'b0, 0, 0);
      idle(200);

      // Randomised mix of writes, commits, boundaries and rare resets
      for (int i = 0; i < 3000; i++) begin
         pick(h, v);
         if ($urandom_range(0, 39) == 0) begin
            boundary();
         end else if ($urandom_range(0, 499) == 0) begin
            issue(h, v, 1'b1, 1'b0, 0, 0);
         end else if ($urandom_range(0, 3) == 0) begin
            issue(h, v, 1'b0, 1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)));
         end else begin
            issue(h, v, 1'b0, 1'b0, 0, 0);
         end
      end

      idle(4);
      @(posedge clk);
      #2;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
